// File: rtl/ssram_arbiter.sv
// ---------------------------------------------------------------------------
// ssram_arbiter
//   Round-robin arbiter sharing one single-port synchronous SRAM (x32, byte
//   enables, write-first, 1-cycle read latency) between requesters A and B.
//   Grants are combinational in the request cycle. RAM enables and strobes
//   follow the granted command in that same cycle. Read data is steered back
//   to the requester that issued the read.
//
//   Optional feature: define SSRAM_INIT_EN to sweep the whole RAM with
//   INIT_VAL after reset. Requests wait until init_done is set. Without the
//   macro, init_done is constant 1.
//
// Ports
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   a_req/we/wb/addr/din port A command (held stable until a_gnt)
//   a_gnt                port A command accepted this cycle
//   a_rvalid/a_rdata     port A read return (rdata is 0 when rvalid is 0)
//   b_*                  identical set for port B
//   ram_enb/ram_wb       per-byte RAM enable / write strobe
//   ram_addr/ram_din     RAM word address / write data (held while idle)
//   ram_dout             RAM read data, valid 1 cycle after enable
//   init_done            RAM available to requesters
// ---------------------------------------------------------------------------
module ssram_arbiter #(
  parameter int          AW       = 12,
  parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [3:0]    a_wb,
  input  logic [AW-3:0] a_addr,
  input  logic [31:0]   a_din,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [31:0]   a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [3:0]    b_wb,
  input  logic [AW-3:0] b_addr,
  input  logic [31:0]   b_din,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [31:0]   b_rdata,
  output logic [3:0]    ram_enb,
  output logic [3:0]    ram_wb,
  output logic [AW-3:0] ram_addr,
  output logic [31:0]   ram_din,
  input  logic [31:0]   ram_dout,
  output logic          init_done
);

  localparam int WAW = AW - 2;

  logic           w_run;        // arbitration enabled
  logic           w_init;       // init sweep drives the RAM this cycle
  logic [WAW-1:0] w_init_addr;
  logic [31:0]    w_init_data;

  logic           w_a_gnt, w_b_gnt;
  logic [3:0]     w_enb, w_wb;
  logic [WAW-1:0] w_addr;
  logic [31:0]    w_din;

  logic           r_last_b;     // 1: last grant went to B
  logic           r_a_rvalid, r_b_rvalid;
  logic [WAW-1:0] r_addr;
  logic [31:0]    r_din;

  assign w_init_data = INIT_VAL;

`ifdef SSRAM_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t         r_state;
  logic [WAW-1:0] r_cnt;
  logic           r_init_done;

  // One word per cycle; the edge after the last write moves to RUN.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else if (r_state == ST_INIT) begin
      r_cnt <= r_cnt + 1'b1;
      if (&r_cnt) begin
        r_state     <= ST_RUN;
        r_init_done <= 1'b1;
      end
    end
  end

  // State is INIT while reset is held, so the sweep is gated by HRESETn to
  // keep the RAM strobes at their reset value.
  assign w_run       = (r_state == ST_RUN);
  assign w_init      = HRESETn & (r_state == ST_INIT);
  assign w_init_addr = r_cnt;
  assign init_done   = r_init_done;
`else
  // Grants are gated by reset so every output reaches its reset value
  // immediately, even though the arbiter is otherwise always available.
  assign w_run       = HRESETn;
  assign w_init      = 1'b0;
  assign w_init_addr = '0;
  assign init_done   = 1'b1;
`endif

  // Round robin: on contention the port that was not granted last wins.
  assign w_a_gnt = w_run & a_req & (~b_req | r_last_b);
  assign w_b_gnt = w_run & b_req & (~a_req | ~r_last_b);

  // RAM command mux. Address and data fall back to the hold registers when
  // idle, so the address bus only changes when a new access is issued.
  always_comb begin
    w_enb  = '0;
    w_wb   = '0;
    w_addr = r_addr;
    w_din  = r_din;
    if (w_init) begin
      w_enb  = 4'hF;
      w_wb   = 4'hF;
      w_addr = w_init_addr;
      w_din  = w_init_data;
    end else if (w_a_gnt) begin
      w_addr = a_addr;
      if (a_we) begin
        w_enb = a_wb;
        w_wb  = a_wb;
        w_din = a_din;
      end else begin
        w_enb = 4'hF;
        w_din = '0;
      end
    end else if (w_b_gnt) begin
      w_addr = b_addr;
      if (b_we) begin
        w_enb = b_wb;
        w_wb  = b_wb;
        w_din = b_din;
      end else begin
        w_enb = 4'hF;
        w_din = '0;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_last_b   <= 1'b1;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
    end else begin
      if (w_a_gnt)      r_last_b <= 1'b0;
      else if (w_b_gnt) r_last_b <= 1'b1;
      // At most one grant per cycle, so the two rvalids are exclusive.
      r_a_rvalid <= w_a_gnt & ~a_we;
      r_b_rvalid <= w_b_gnt & ~b_we;
      r_addr     <= w_addr;
      r_din      <= w_din;
    end
  end

  assign a_gnt    = w_a_gnt;
  assign b_gnt    = w_b_gnt;
  assign ram_enb  = w_enb;
  assign ram_wb   = w_wb;
  assign ram_addr = w_addr;
  assign ram_din  = w_din;
  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;
  assign a_rdata  = r_a_rvalid ? ram_dout : '0;
  assign b_rdata  = r_b_rvalid ? ram_dout : '0;

endmodule

// File: doc/ssram_arbiter.md
Name: ssram_arbiter

Overview:
- Two-port arbiter sharing one single-port synchronous SRAM (per-byte enables/write strobes, write-first, 1-cycle read latency) between requesters A and B.
- Port A is normally fed by the AHB-to-SSRAM bridge; port B by a secondary master (DMA/debug).
- Sits between the requesters and the four byte-lane RAMs (or one x32 RAM).
- Performs round-robin arbitration, drives the RAM strobes and returns read data to the requester that issued the read.

Parameters:
- AW, 12: byte address width; RAM word address is AW-2 bits (1024 words at default).
- INIT_VAL, 32'h0000_0000: data word written during the init sweep (used only with SSRAM_INIT_EN).

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous reset, active low.
- a_req  in  1  port A access request; held with stable command until a_gnt.
- a_we  in  1  port A write (1) / read (0).
- a_wb  in  4  port A byte write mask; ignored on reads.
- a_addr  in  AW-2  port A word address.
- a_din  in  32  port A write data.
- a_gnt  out  1  port A command accepted this cycle.
- a_rvalid  out  1  port A read data valid.
- a_rdata  out  32  port A read data.
- b_req, b_we, b_wb, b_addr, b_din, b_gnt, b_rvalid, b_rdata: identical set for port B.
- ram_enb  out  4  per-byte RAM enable.
- ram_wb  out  4  per-byte RAM write strobe.
- ram_addr  out  AW-2  RAM word address.
- ram_din  out  32  RAM write data.
- ram_dout  in  32  RAM read data, valid 1 cycle after enable.
- init_done  out  1  RAM available to requesters.

Behaviour:
- Reset values:
  - a_gnt, b_gnt, a_rvalid, b_rvalid, ram_enb, ram_wb = 0.
  - a_rdata, b_rdata, ram_addr, ram_din = 0.
  - Round-robin pointer last_gnt = B, so A wins the first contention.
  - init_done: see Optional Feature.
- Grant is combinational in the request cycle; one access per cycle max; zero wait when uncontended.
- Arbitration (only when init_done=1):
  - Only one port requesting: that port is granted.
  - Both requesting: the port not equal to last_gnt is granted.
  - last_gnt updates on every grant; no grant leaves it unchanged.
- Granted write:
  - ram_enb = ram_wb = x_wb; ram_addr = x_addr; ram_din = x_din.
  - x_wb = 0 is still granted but produces no RAM activity.
- Granted read:
  - ram_enb = 4'hF, ram_wb = 0; ram_addr = x_addr; ram_din = 0.
- No grant: ram_enb = ram_wb = 0; ram_addr and ram_din hold their last value (registered hold mux, glitch-free address).
- Read return:
  - x_rvalid is registered: x_rvalid <= x_gnt & ~x_we.
  - x_rdata = ram_dout while x_rvalid = 1, else 0.
  - The two rvalids are never high together.
- Ordering: accesses take effect in grant order. A read granted the cycle after a write to the same address returns the new data.
- Requester rule: while x_req=1 and x_gnt=0, the command must stay stable. The arbiter does not check this.
- Back-to-back: a port may be granted on consecutive cycles when the other port is idle.
- Asynchronous reset mid-operation:
  - All outputs return to reset values immediately.
  - A pending rvalid is dropped.
  - The init sweep restarts from word 0 when enabled.

Optional Feature:
- Macro: SSRAM_INIT_EN.
- Defined: two-state FSM, INIT -> RUN.
  - INIT: a word counter runs 0 .. 2^(AW-2)-1, one word per cycle, with ram_enb = ram_wb = 4'hF, ram_din = INIT_VAL, ram_addr = counter.
  - a_gnt = b_gnt = 0 in INIT; requests wait.
  - The sweep's last write occurs in cycle 2^(AW-2) after reset release.
  - init_done resets to 0 and is registered to 1 together with the RUN transition, at the clock edge after the last write.
  - RUN is terminal until reset.
- Undefined: no FSM and no counter; init_done is constant 1, including during reset.

Test Plan:
- Init (SSRAM_INIT_EN, AW=12):
  - Stimulus: release reset with a_req=1.
  - Response: exactly 1024 writes of INIT_VAL to addresses 0..1023; a_gnt=0 throughout; init_done rises after the last write; the next cycle grants A.
- A write then read:
  - Stimulus: A writes 0xDEADBEEF, wb=4'hF, addr 0x010; next cycle A reads 0x010.
  - Response: a_rvalid=1 one cycle after the read grant; a_rdata=0xDEADBEEF; b_rvalid=0.
- Byte lane:
  - Stimulus: B writes 0x000000AA, wb=4'b0001, to addr 5 (pre-initialised to 0x11223344); B reads addr 5.
  - Response: ram_enb=ram_wb=4'b0001 during the write; b_rdata=0x112233AA.
- Contention:
  - Stimulus: a_req=b_req=1, both held for 4 reads.
  - Response: grants alternate A,B,A,B from reset pointer; each rvalid on its own port one cycle later.
- Write-read race:
  - Stimulus: A writes 0x55 to addr 7; B reads addr 7 contending in the same cycle (A wins).
  - Response: B granted the next cycle; b_rdata=0x55.
- Reset mid-operation:
  - Stimulus: assert HRESETn low during a granted read and again mid-init.
  - Response: a_rvalid stays 0; all outputs go to reset values immediately; init restarts at address 0.
